// File: rtl/int_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : int_alu_pkg
// Brief   : Shared constants and helpers for the integer ALU multiply slice.
// Revision: 1.0 - initial release
// ============================================================================
package int_alu_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int MAX_REQ            = 16;

  // Width of an index that names one of n items; never narrower than one bit
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : int_alu_pkg
`default_nettype wire

// File: rtl/int_mult.sv
`default_nettype none
// ============================================================================
// Module  : int_mult
// Brief   : Combinational unsigned multiplier returning the low half of a*b.
// Revision: 1.0 - initial release
// ============================================================================
module int_mult #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] p
);

  // Product evaluated at operand width so the high half is dropped
  assign p = a * b;

endmodule : int_mult
`default_nettype wire

// File: rtl/int_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : int_rr_arb
// Brief   : Round-robin grant finder. Picks the first set request at or
//           above ptr, wrapping to 0; returns one-hot grant and its index.
// Revision: 1.0 - initial release
// ============================================================================
module int_rr_arb
  import int_alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  // Walk candidates in priority order starting at ptr; first hit wins
  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule : int_rr_arb
`default_nettype wire

// File: rtl/int_mult_sched.sv
`default_nettype none
// ============================================================================
// Module  : int_mult_sched
// Brief   : Shares one int_mult among NUM_REQ requesters with round-robin
//           arbitration and a two-stage valid/ready pipeline. Results are
//           tagged with the requester index and return in accept order.
// Revision: 1.0 - initial release
// ============================================================================
module int_mult_sched
  import int_alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int NUM_REQ    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [clog2_min1(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            busy
);

  localparam int ID_W = clog2_min1(NUM_REQ);

  logic [ID_W-1:0]       ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  adv1;
  logic                  adv2;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [DATA_WIDTH-1:0] product;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [ID_W-1:0]       s1_id;

  int_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  int_mult #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (product)
  );

  // Each stage moves when the stage ahead is empty or draining this cycle
  assign adv2      = ~rsp_valid | rsp_ready;
  assign adv1      = ~s1_valid | adv2;
  assign req_ready = grant & {NUM_REQ{adv1 & ~rst}};
  assign accept    = |req_ready;
  assign busy      = s1_valid | rsp_valid;

  // Operand mux driven by the one-hot grant
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a = sel_a | (req_a[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
      sel_b = sel_b | (req_b[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end

  // Stage 1 capture and round-robin pointer update on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_id    <= grant_idx;
      if (grant_idx == ID_W'(NUM_REQ - 1)) ptr <= '0;
      else                                 ptr <= grant_idx + 1'b1;
    end else if (adv1) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 result register; payload only reloads when stage 1 carries work
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (adv2) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= product;
        rsp_id   <= s1_id;
      end
    end
  end

endmodule : int_mult_sched
`default_nettype wire
